// File: rtl/fir_y_collector.sv
// Output collector for the FIR / matrix-multiply accelerator.
// Buffers AXI-Stream results in a FIFO and exposes them via Wishbone registers.
module fir_y_collector #(
    parameter int pDATA_WIDTH = 32,
    parameter int DEPTH       = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_dat_i,
    input  logic [31:0]            wbs_adr_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   ss_tready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [pDATA_WIDTH:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wp;
    logic [AW-1:0]        r_rp;
    logic [CW-1:0]        r_count;
    logic [CNT_WIDTH-1:0] r_wcount;
    logic                 r_frame_done;
    logic                 r_underflow;
    logic                 r_last_pop;

    logic                 w_access;
    logic                 w_rd;
    logic                 w_wr;
    logic [1:0]           w_reg;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_underrun;
    logic                 w_flush;
    logic                 w_stat_wr;
    logic [pDATA_WIDTH:0] w_head;
    logic [31:0]          w_rdata;
    logic                 w_unused;

    assign w_access   = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign w_rd       = w_access & ~wbs_we_i;
    assign w_wr       = w_access & wbs_we_i;
    assign w_reg      = wbs_adr_i[3:2];
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign ss_tready  = ~w_full;
    assign w_push     = ss_tvalid & ss_tready;
    assign w_pop      = w_rd & (w_reg == 2'd0) & ~w_empty;
    assign w_underrun = w_rd & (w_reg == 2'd0) & w_empty;
    assign w_flush    = w_wr & (w_reg == 2'd3) & wbs_sel_i[0] & wbs_dat_i[0];
    assign w_stat_wr  = w_wr & (w_reg == 2'd1) & wbs_sel_i[0];
    assign w_head     = r_mem[r_rp];
    assign w_unused   = &{1'b0, wbs_sel_i[3:1], wbs_dat_i[31:4], wbs_dat_i[1],
                          wbs_adr_i[31:4], wbs_adr_i[1:0]};

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            2'd0: if (!w_empty) w_rdata[pDATA_WIDTH-1:0] = w_head[pDATA_WIDTH-1:0];
            2'd1: begin
                w_rdata[0]    = w_empty;
                w_rdata[1]    = w_full;
                w_rdata[2]    = r_frame_done;
                w_rdata[3]    = r_underflow;
                w_rdata[4]    = r_last_pop;
                w_rdata[15:8] = 8'(r_count);
            end
            2'd2: w_rdata[CNT_WIDTH-1:0] = r_wcount;
            default: w_rdata = '0;
        endcase
    end

    // Storage is deliberately left out of reset; pointers/count guard its contents.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= {ss_tlast, ss_tdata};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wcount     <= '0;
            r_frame_done <= 1'b0;
            r_underflow  <= 1'b0;
            r_last_pop   <= 1'b0;
        end else if (w_flush) begin
            r_wcount     <= '0;
            r_frame_done <= 1'b0;
            r_underflow  <= 1'b0;
            r_last_pop   <= 1'b0;
        end else begin
            if (w_push && (r_wcount != '1)) r_wcount <= r_wcount + CNT_WIDTH'(1);
            // Set has priority over a same-cycle software clear.
            if (w_push && ss_tlast)                 r_frame_done <= 1'b1;
            else if (w_stat_wr && wbs_dat_i[2])     r_frame_done <= 1'b0;
            if (w_underrun)                         r_underflow  <= 1'b1;
            else if (w_stat_wr && wbs_dat_i[3])     r_underflow  <= 1'b0;
            if (w_pop) r_last_pop <= w_head[pDATA_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= w_access;
            if (w_access) wbs_dat_o <= wbs_we_i ? 32'h0 : w_rdata;
        end
    end

endmodule

// File: tb/tb_fir_y_collector.sv
// Directed self-checking bench for fir_y_collector (DEPTH=8).
module tb_fir_y_collector;

    logic        clk;
    logic        rst;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        ss_tvalid;
    logic [31:0] ss_tdata;
    logic        ss_tlast;
    logic        ss_tready;

    int unsigned n_cmp;
    int unsigned n_bad;

    localparam logic [31:0] A_DATA = 32'h0;
    localparam logic [31:0] A_STAT = 32'h4;
    localparam logic [31:0] A_WCNT = 32'h8;
    localparam logic [31:0] A_CTRL = 32'hC;

    fir_y_collector #(
        .pDATA_WIDTH(32),
        .DEPTH      (8),
        .CNT_WIDTH  (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wbs_stb_i(wbs_stb_i),
        .wbs_cyc_i(wbs_cyc_i),
        .wbs_we_i (wbs_we_i),
        .wbs_sel_i(wbs_sel_i),
        .wbs_dat_i(wbs_dat_i),
        .wbs_adr_i(wbs_adr_i),
        .wbs_ack_o(wbs_ack_o),
        .wbs_dat_o(wbs_dat_o),
        .ss_tvalid(ss_tvalid),
        .ss_tdata (ss_tdata),
        .ss_tlast (ss_tlast),
        .ss_tready(ss_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        if (wbs_ack_o) @(negedge clk);
        wbs_adr_i = a; wbs_we_i = 1'b0; wbs_sel_i = 4'h0; wbs_dat_i = '0;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        @(posedge clk); #1;
        check("rd_ack", {31'b0, wbs_ack_o}, 32'h1);
        d = wbs_dat_o;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] v, input logic [3:0] s);
        @(negedge clk);
        if (wbs_ack_o) @(negedge clk);
        wbs_adr_i = a; wbs_we_i = 1'b1; wbs_sel_i = s; wbs_dat_i = v;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        @(posedge clk); #1;
        check("wr_ack", {31'b0, wbs_ack_o}, 32'h1);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        wb_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        int unsigned n;
        @(negedge clk);
        ss_tvalid = 1'b1; ss_tdata = d; ss_tlast = l;
        n = 0;
        while (!ss_tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ss_tready) check("push_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
        ss_tvalid = 1'b0; ss_tlast = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int unsigned got;
        n_cmp = 0; n_bad = 0;
        rst = 1'b1;
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wbs_sel_i = '0;
        wbs_dat_i = '0; wbs_adr_i = '0;
        ss_tvalid = 0; ss_tdata = '0; ss_tlast = 0;

        #3 rst = 1'b0;
        #1;
        check("rst_tready", {31'b0, ss_tready}, 32'h1);
        check("rst_ack", {31'b0, wbs_ack_o}, 32'h0);
        check("rst_dat", wbs_dat_o, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rd_check("idle_status", A_STAT, 32'h0000_0001);
        rd_check("idle_wcount", A_WCNT, 32'h0);

        // Fill and backpressure
        for (int i = 0; i < 8; i++) push(32'h11 + i, 1'b0);
        check("full_tready", {31'b0, ss_tready}, 32'h0);
        rd_check("full_status", A_STAT, 32'h0000_0802);
        @(negedge clk);
        ss_tvalid = 1'b1; ss_tdata = 32'h19; ss_tlast = 1'b0;
        check("held_tready", {31'b0, ss_tready}, 32'h0);
        wb_read(A_DATA, d);
        check("first_pop", d, 32'h11);
        check("tready_after_pop", {31'b0, ss_tready}, 32'h1);
        @(posedge clk); #1;
        ss_tvalid = 1'b0;
        rd_check("refill_status", A_STAT, 32'h0000_0802);
        for (int i = 0; i < 8; i++) rd_check("drain", A_DATA, 32'h12 + i);
        rd_check("drained_status", A_STAT, 32'h0000_0001);
        rd_check("wcount9", A_WCNT, 32'd9);

        // Continuous stream with concurrent reads, wrapping the pointers
        got = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) push(32'h100 + i, 1'b0);
            end
            begin
                for (int k = 0; k < 200 && got < 20; k++) begin
                    wb_read(A_DATA, d);
                    if (d != 32'h0) begin
                        check("stream_seq", d, 32'h100 + got);
                        got++;
                    end
                end
            end
        join
        check("stream_count", got, 32'd20);
        wb_write(A_STAT, 32'h8, 4'h1);
        rd_check("stream_status", A_STAT, 32'h0000_0001);

        // Flush
        for (int i = 0; i < 4; i++) push(32'h31 + i, 1'b0);
        rd_check("pre_flush_status", A_STAT, 32'h0000_0400);
        rd_check("pre_flush_wcount", A_WCNT, 32'd33);
        wb_write(A_CTRL, 32'h1, 4'h1);
        rd_check("flush_status", A_STAT, 32'h0000_0001);
        rd_check("flush_wcount", A_WCNT, 32'h0);
        rd_check("ctrl_read", A_CTRL, 32'h0);
        push(32'hAB, 1'b0);
        rd_check("post_flush_data", A_DATA, 32'hAB);

        // Frame end
        wb_write(A_CTRL, 32'h1, 4'h1);
        for (int i = 0; i < 5; i++) push(32'h21 + i, i == 4);
        rd_check("frame_status", A_STAT, 32'h0000_0504);
        rd_check("frame_wcount", A_WCNT, 32'd5);
        for (int i = 0; i < 4; i++) rd_check("frame_data", A_DATA, 32'h21 + i);
        rd_check("pre_last_status", A_STAT, 32'h0000_0104);
        rd_check("last_data", A_DATA, 32'h25);
        rd_check("last_pop_status", A_STAT, 32'h0000_0015);
        wb_write(A_STAT, 32'hC, 4'h0);
        rd_check("sel0_ignored", A_STAT, 32'h0000_0015);
        wb_write(A_STAT, 32'h4, 4'h1);
        rd_check("frame_cleared", A_STAT, 32'h0000_0011);

        // Underflow
        rd_check("underflow_data", A_DATA, 32'h0);
        rd_check("underflow_status", A_STAT, 32'h0000_0019);
        wb_write(A_STAT, 32'h8, 4'h1);
        rd_check("underflow_cleared", A_STAT, 32'h0000_0011);

        // Asynchronous reset while full and mid-acknowledge
        for (int i = 0; i < 8; i++) push(32'h41 + i, 1'b0);
        check("mid_full_tready", {31'b0, ss_tready}, 32'h0);
        @(negedge clk);
        wbs_adr_i = A_DATA; wbs_we_i = 1'b0; wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        @(posedge clk); #1;
        check("mid_ack", {31'b0, wbs_ack_o}, 32'h1);
        check("mid_data", wbs_dat_o, 32'h41);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_ack", {31'b0, wbs_ack_o}, 32'h0);
        check("mid_rst_tready", {31'b0, ss_tready}, 32'h1);
        check("mid_rst_dat", wbs_dat_o, 32'h0);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rd_check("post_rst_status", A_STAT, 32'h0000_0001);
        rd_check("post_rst_wcount", A_WCNT, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fir_y_collector.md
# fir_y_collector

Downstream stage of the FIR / matrix-multiply accelerator. It accepts the accelerator's AXI-Stream output (y samples or MM results), buffers them in a small FIFO, and presents them to the CPU as Wishbone-readable registers. Software drains results by polling status and reading a data register. It also counts words and frames so firmware can detect end-of-stream (tlast) without tracking sample counts itself.

## Interface
Parameters:
- pDATA_WIDTH, 32, stream and Wishbone data width
- DEPTH, 8, FIFO depth in words; power of two, 2..64
- CNT_WIDTH, 16, width of the word counter

Ports:
- clk  input  1  single clock for all logic
- rst  input  1  reset, asynchronous, active-low
- wbs_stb_i  input  1  Wishbone strobe
- wbs_cyc_i  input  1  Wishbone cycle
- wbs_we_i  input  1  write enable (1 = write)
- wbs_sel_i  input  4  byte enables; only sel[0] is used, on writes
- wbs_dat_i  input  32  write data
- wbs_adr_i  input  32  address; only adr[3:2] is decoded; base decode is external
- wbs_ack_o  output  1  registered acknowledge
- wbs_dat_o  output  32  registered read data
- ss_tvalid  input  1  stream valid from accelerator sm_tvalid
- ss_tdata  input  pDATA_WIDTH  stream data from accelerator sm_tdata
- ss_tlast  input  1  end-of-frame from accelerator sm_tlast
- ss_tready  output  1  ready to the accelerator sm_tready

## Operation
- FIFO entries hold {tlast, tdata}, with write pointer wp, read pointer rp, and occupancy count (0..DEPTH).
- Push: ss_tvalid & ss_tready. ss_tready = (count != DEPTH), derived from registered count only. There is no same-cycle bypass: when the FIFO is full and a pop happens, ss_tready stays 0 in that cycle.
- Register map, indexed by adr[3:2]:
  - 0 DATA (read-only). A read pops the head word and returns tdata. Bit STATUS.last_pop takes the popped entry's tlast. Reading while empty returns 0, does not move pointers, and sets sticky underflow.
  - 1 STATUS. Read bits: [0] empty, [1] full, [2] frame_done (sticky, set when a word with tlast is pushed), [3] underflow (sticky), [4] last_pop, [15:8] count (zero-extended), rest 0. Writing with sel[0]=1 clears frame_done if dat[2]=1 and underflow if dat[3]=1. A write with sel[0]=0 is acked and has no effect.
  - 2 WCOUNT (read-only). Number of words pushed since the last clear. Saturates at all-ones.
  - 3 CTRL (write). Writing dat[0]=1 with sel[0]=1 flushes: rp=wp=count=0, WCOUNT=0, frame_done, underflow and last_pop cleared. Reads return 0.
- Writes to DATA and WCOUNT are acked and ignored.
- Counting:
  - Push without pop: count+1.
  - Pop without push: count-1.
  - Push and pop in the same cycle: count unchanged, and the stored word is not corrupted.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Flush in the same cycle as a push: flush wins and the pushed word is discarded. The accelerator must be idle during a flush, which is a software rule.
- frame_done set and clear in the same cycle: set wins.

## Timing
- Reset (rst=0, asynchronous): wbs_ack_o=0, wbs_dat_o=0, ss_tready=1 (count=0), pointers 0, WCOUNT 0, all sticky bits 0. FIFO storage is not reset.
- Wishbone:
  - In a cycle with wbs_stb_i & wbs_cyc_i & !wbs_ack_o, the register access takes effect at the next edge.
  - wbs_ack_o is 1 for exactly that following cycle, with wbs_dat_o valid.
  - Back-to-back accesses therefore ack every second cycle.
  - The pop, pointer update and sticky updates occur at the same edge that raises ack.
- Stream latency:
  - A word pushed at edge N is visible in count/empty from cycle N+1.
  - A DATA read started in cycle N+1 returns that word with ack in cycle N+2.
- A DATA read and a push in the same cycle when count=0: the read sees empty, returns 0 and sets underflow. The pushed word remains queued.
- wbs_dat_o holds its last value when ack=0.

## Test plan
- Reset and idle: assert rst=0 mid-stream with count=3 -> immediately ss_tready=1 and ack=0. After release, STATUS reads 0x0000_0001 and WCOUNT reads 0.
- Fill and backpressure (DEPTH=8): push 0x11..0x18 with tvalid held -> ss_tready=0 after the 8th push, and STATUS = full, count=8. A 9th word 0x19 is held, then accepted one cycle after the first DATA read returns 0x11.
- Simultaneous push/pop: stream continuously while reading DATA every access -> reads return a strictly increasing sequence with no loss or duplication. Count stays within 0..8 and wraps past index 7 correctly.
- Frame end: push 5 words, the last with tlast=1 -> STATUS[2]=1 and WCOUNT=5. The 5th DATA read sets STATUS[4]=1. Writing STATUS with 0x4 and sel=0x1 clears bit 2.
- Underflow: DATA read when empty -> returns 0, STATUS[3]=1, count stays 0. Writing STATUS with 0x8 clears it.
- Flush: with 4 words queued, write CTRL with 0x1 -> next STATUS reads 0x0000_0001, WCOUNT=0, and the next pushed word 0xAB is the first word read back.
